// File: rtl/shared_channel_pkg.sv
// shared_channel_pkg: FSM state type and depth helper for the PS-PL shared channel
package shared_channel_pkg;
  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;
  function automatic int depth_of(input int addr_width);
    return 1 << addr_width;
  endfunction
endpackage

// File: rtl/sdp_bram.sv
// sdp_bram: simple-dual-port RAM, registered read, no array reset so it maps to block RAM
module sdp_bram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/shared_ring_buffer.sv
// shared_ring_buffer: scrubbed BRAM ring buffer with FWFT read side, occupancy and sticky overflow
module shared_ring_buffer
  import shared_channel_pkg::*;
#(
  parameter int          DATA_WIDTH   = 32,
  parameter int          ADDR_WIDTH   = 6,
  parameter logic [31:0] FILL_VALUE   = 32'hAAAAAAAA,
  parameter int          AFULL_THRESH = depth_of(ADDR_WIDTH) - 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  almost_full,
  output logic                  overflow,
  input  logic                  clr_overflow,
  output logic                  init_done
);
  localparam int DEPTH = depth_of(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] FULL = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL = (ADDR_WIDTH+1)'(AFULL_THRESH);
  state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0] count_q, count_d, ram_cnt;
  logic pend_q, pend_d, out_valid_q, out_valid_d, afull_q, ovf_q, ovf_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d, ram_rdata, ram_wdata;
  logic run, push, pop, adv, re, we;
  assign run = state_q == ST_RUN;
  assign wr_ready = run && (count_q < FULL);
  assign push = wr_valid && wr_ready;
  assign pop = out_valid_q && rd_ready;
  // pend_q marks a word sitting in the RAM output register, one stage behind the head register
  assign adv = pend_q && (!out_valid_q || pop);
  assign ram_cnt = count_q - {{ADDR_WIDTH{1'b0}}, pend_q} - {{ADDR_WIDTH{1'b0}}, out_valid_q};
  assign re = (ram_cnt != '0) && (!pend_q || adv);
  // the write pointer doubles as the scrub address and wraps back to 0 when INIT ends
  assign we = !run || push;
  assign ram_wdata = run ? wr_data : DATA_WIDTH'(FILL_VALUE);
  always_comb begin
    state_d = (!run && wr_ptr_q == '1) ? ST_RUN : state_q;
    wr_ptr_d = we ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = re ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d = count_q + {{ADDR_WIDTH{1'b0}}, push} - {{ADDR_WIDTH{1'b0}}, pop};
    pend_d = re ? 1'b1 : (adv ? 1'b0 : pend_q);
    out_valid_d = adv ? 1'b1 : (pop ? 1'b0 : out_valid_q);
    out_data_d = adv ? ram_rdata : out_data_q;
    ovf_d = (run && wr_valid && !wr_ready) ? 1'b1 : (clr_overflow ? 1'b0 : ovf_q);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      pend_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      afull_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      pend_q <= pend_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      afull_q <= count_d >= AFULL;
      ovf_q <= ovf_d;
    end
  end
  sdp_bram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk(clk),
    .we(we),
    .waddr(wr_ptr_q),
    .wdata(ram_wdata),
    .re(re),
    .raddr(rd_ptr_q),
    .rdata(ram_rdata)
  );
  assign rd_valid = out_valid_q;
  assign rd_data = out_data_q;
  assign count = count_q;
  assign almost_full = afull_q;
  assign overflow = ovf_q;
  assign init_done = run;
endmodule

// File: tb/tb_shared_ring_buffer.sv
// tb_shared_ring_buffer: randomized checks against a queue-based model of the ring buffer
module tb_shared_ring_buffer;
  localparam int DW = 32;
  localparam int AW = 6;
  localparam int DEPTH = 64;
  localparam int AF = 60;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic wr_valid = 1'b0;
  logic rd_ready = 1'b0;
  logic clr_overflow = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic wr_ready, rd_valid, almost_full, overflow, init_done;
  logic [DW-1:0] rd_data;
  logic [AW:0] count;
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] mq[$];
  logic m_ovf = 1'b0;
  logic m_init = 1'b0;

  always #5 clk = ~clk;

  shared_ring_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .count(count),
    .almost_full(almost_full), .overflow(overflow), .clr_overflow(clr_overflow), .init_done(init_done)
  );

  // model update for the coming edge, then advance to 1 time unit past it
  task automatic tick();
    logic exp_wrr;
    exp_wrr = m_init && (mq.size() < DEPTH);
    if (m_init && wr_valid && !exp_wrr) m_ovf = 1'b1;
    else if (clr_overflow) m_ovf = 1'b0;
    if (rd_valid && rd_ready && mq.size() > 0) void'(mq.pop_front());
    if (wr_valid && exp_wrr) mq.push_back(wr_data);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int n;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_wr_ready: got %b expected 0", wr_ready); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
    checks++; if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data: got %0h expected 0", rd_data); end
    checks++; if (count !== '0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_almost_full: got %b expected 0", almost_full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done: got %b expected 0", init_done); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (!init_done && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++; if (n != DEPTH) begin errors++; $display("FAIL init_length: got %0d cycles expected %0d", n, DEPTH); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL init_wr_ready: got %b expected 1", wr_ready); end
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (dut.u_ram.mem[AW'(i)] !== 32'hAAAAAAAA) begin errors++; $display("FAIL scrub_entry_%0d: got %0h expected aaaaaaaa", i, dut.u_ram.mem[AW'(i)]); end
    end
    m_init = 1'b1;
  endtask

  task automatic test_fifo_order();
    logic [DW-1:0] vals [3];
    vals = '{32'h11, 32'h22, 32'h33};
    rd_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1;
      wr_data = vals[i];
      tick();
    end
    wr_valid = 1'b0;
    tick();
    tick();
    checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL order_head_valid: got %b expected 1", rd_valid); end
    rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (rd_data !== vals[i]) begin errors++; $display("FAIL order_data_%0d: got %0h expected %0h", i, rd_data, vals[i]); end
      checks++; if (count !== (AW+1)'(3 - i)) begin errors++; $display("FAIL order_count_%0d: got %0d expected %0d", i, count, 3 - i); end
      tick();
    end
    checks++; if (count !== '0) begin errors++; $display("FAIL order_count_end: got %0d expected 0", count); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL order_empty_valid: got %b expected 0", rd_valid); end
    tick();
    checks++; if (rd_data !== 32'h33) begin errors++; $display("FAIL order_hold_data: got %0h expected 33", rd_data); end
    rd_ready = 1'b0;
  endtask

  task automatic test_fill_overflow();
    rd_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      checks++; if (count !== (AW+1)'(i)) begin errors++; $display("FAIL fill_count_%0d: got %0d expected %0d", i, count, i); end
      checks++; if (almost_full !== (i >= AF)) begin errors++; $display("FAIL fill_afull_%0d: got %b expected %b", i, almost_full, i >= AF); end
      checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL fill_wr_ready_%0d: got %b expected 1", i, wr_ready); end
      wr_valid = 1'b1;
      wr_data = $urandom;
      tick();
    end
    checks++; if (count !== (AW+1)'(DEPTH)) begin errors++; $display("FAIL full_count: got %0d expected 64", count); end
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL full_wr_ready: got %b expected 0", wr_ready); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_overflow_pre: got %b expected 0", overflow); end
    wr_data = 32'hDEADBEEF;
    tick();
    wr_valid = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_set: got %b expected 1", overflow); end
    checks++; if (count !== (AW+1)'(mq.size())) begin errors++; $display("FAIL overflow_drop_count: got %0d expected %0d", count, mq.size()); end
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL overflow_clear: got %b expected 0", overflow); end
    wr_valid = 1'b1;
    clr_overflow = 1'b1;
    tick();
    wr_valid = 1'b0;
    clr_overflow = 1'b0;
    checks++; if (overflow !== m_ovf || overflow !== 1'b1) begin errors++; $display("FAIL overflow_set_wins: got %b expected 1", overflow); end
  endtask

  task automatic test_wrap_stream();
    int n;
    wr_valid = 1'b1;
    rd_ready = 1'b1;
    for (int c = 0; c < 200; c++) begin
      wr_data = $urandom;
      if (rd_valid) begin
        checks++; if (mq.size() == 0 || rd_data !== mq[0]) begin errors++; $display("FAIL wrap_data_%0d: got %0h expected %0h", c, rd_data, mq.size() > 0 ? mq[0] : '0); end
      end
      tick();
    end
    checks++; if (count < 7'd63 || count > 7'd64) begin errors++; $display("FAIL wrap_count_range: got %0d expected 63..64", count); end
    checks++; if (count !== (AW+1)'(mq.size())) begin errors++; $display("FAIL wrap_count_model: got %0d expected %0d", count, mq.size()); end
    checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL wrap_overflow: got %b expected %b", overflow, m_ovf); end
    wr_valid = 1'b0;
    n = 0;
    while (mq.size() > 0 && n < 300) begin
      if (rd_valid) begin
        checks++; if (rd_data !== mq[0]) begin errors++; $display("FAIL drain_data: got %0h expected %0h", rd_data, mq[0]); end
      end
      tick();
      n++;
    end
    checks++; if (mq.size() != 0 || count !== '0) begin errors++; $display("FAIL drain_timeout: got count %0d expected 0", count); end
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    rd_ready = 1'b0;
    tick();
  endtask

  task automatic test_latency();
    logic [DW-1:0] a, b;
    int n;
    a = $urandom;
    b = $urandom;
    rd_ready = 1'b0;
    wr_valid = 1'b1;
    wr_data = a;
    tick();
    wr_valid = 1'b0;
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL lat_k: got %b expected 0", rd_valid); end
    tick();
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL lat_k1: got %b expected 0", rd_valid); end
    tick();
    checks++; if (rd_valid !== 1'b1 || rd_data !== a) begin errors++; $display("FAIL lat_k2: got valid %b data %0h expected 1 %0h", rd_valid, rd_data, a); end
    wr_valid = 1'b1;
    wr_data = b;
    rd_ready = 1'b1;
    tick();
    wr_valid = 1'b0;
    checks++; if (count !== 7'd1) begin errors++; $display("FAIL pushpop_count: got %0d expected 1", count); end
    n = 0;
    while (!rd_valid && n < 5) begin
      tick();
      n++;
    end
    checks++; if (rd_valid !== 1'b1 || rd_data !== b) begin errors++; $display("FAIL pushpop_data: got valid %b data %0h expected 1 %0h", rd_valid, rd_data, b); end
    tick();
    rd_ready = 1'b0;
    checks++; if (count !== '0) begin errors++; $display("FAIL pushpop_drain: got %0d expected 0", count); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      wr_valid = $urandom_range(99) < (c < 300 ? 80 : 30);
      rd_ready = $urandom_range(99) < (c < 300 ? 30 : 80);
      clr_overflow = $urandom_range(15) == 0;
      wr_data = $urandom;
      checks++; if (count !== (AW+1)'(mq.size())) begin errors++; $display("FAIL rnd_count_%0d: got %0d expected %0d", c, count, mq.size()); end
      checks++; if (wr_ready !== (mq.size() < DEPTH)) begin errors++; $display("FAIL rnd_wr_ready_%0d: got %b expected %b", c, wr_ready, mq.size() < DEPTH); end
      checks++; if (almost_full !== (mq.size() >= AF)) begin errors++; $display("FAIL rnd_afull_%0d: got %b expected %b", c, almost_full, mq.size() >= AF); end
      checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL rnd_overflow_%0d: got %b expected %b", c, overflow, m_ovf); end
      if (rd_valid) begin
        checks++; if (mq.size() == 0 || rd_data !== mq[0]) begin errors++; $display("FAIL rnd_data_%0d: got %0h expected %0h", c, rd_data, mq.size() > 0 ? mq[0] : '0); end
      end
      tick();
    end
    clr_overflow = 1'b0;
  endtask

  task automatic test_mid_reset();
    int n;
    wr_valid = 1'b0;
    rd_ready = 1'b1;
    n = 0;
    while (mq.size() > 0 && n < 300) begin
      tick();
      n++;
    end
    rd_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wr_valid = 1'b1;
      wr_data = $urandom;
      tick();
    end
    wr_valid = 1'b0;
    tick();
    tick();
    checks++; if (count !== 7'd10 || rd_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre: got count %0d valid %b expected 10 1", count, rd_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({wr_ready, rd_valid, almost_full, overflow, init_done} !== 5'b0 || count !== '0 || rd_data !== '0) begin
      errors++; $display("FAIL midrst_outputs: got rdy %b vld %b af %b ovf %b done %b count %0d data %0h expected all 0", wr_ready, rd_valid, almost_full, overflow, init_done, count, rd_data);
    end
    mq.delete();
    m_init = 1'b0;
    m_ovf = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (!init_done && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL midrst_stale_valid_%0d: got %b expected 0", n, rd_valid); end
    end
    checks++; if (n != DEPTH) begin errors++; $display("FAIL midrst_init_length: got %0d expected %0d", n, DEPTH); end
    m_init = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (rd_valid !== 1'b0 || count !== '0) begin errors++; $display("FAIL midrst_idle_%0d: got valid %b count %0d expected 0 0", i, rd_valid, count); end
      tick();
    end
    for (int i = 0; i < DEPTH; i += 7) begin
      checks++;
      if (dut.u_ram.mem[AW'(i)] !== 32'hAAAAAAAA) begin errors++; $display("FAIL midrst_scrub_%0d: got %0h expected aaaaaaaa", i, dut.u_ram.mem[AW'(i)]); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fifo_order();
    test_fill_overflow();
    test_wrap_stream();
    test_latency();
    test_random();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
